// File: rtl/burst_scheduler.sv
// burst_scheduler
//   Interrupter-side sequencer for the DRSSTC bridge drive path. Each accepted
//   trigger produces one bounded burst: gate (generator enable) is raised for
//   the requested on-time or until the bridge-cycle limit is reached, then the
//   block waits for the bridge drive to ring down and enforces a holdoff
//   before the next burst can start.
//
//   Ports:
//     clk     in   system clock, rising edge
//     rst_n   in   synchronous active-low reset
//     trig    in   burst request level (synchronized)
//     on_us   in   requested on-time in microseconds, sampled at burst start
//     drv     in   selected bridge drive (selector output)
//     ocd     in   overcurrent detect (synchronized)
//     gate    out  generator enable, high only in RUN
//     active  out  high in RUN or DRAIN
//     fault   out  sticky overcurrent termination flag
//     cycles  out  falling edges of drv counted in the last/current burst
//
//   Build option: define BURST_SCHEDULER_OCD_EN to let ocd terminate a burst
//   and set fault. Undefined, ocd is ignored and fault is tied low.
module burst_scheduler #(
  parameter int unsigned CLK_MHZ    = 100,
  parameter int unsigned ON_US_W    = 10,
  parameter int unsigned MAX_CYCLES = 32,
  parameter int unsigned DRAIN_US   = 4,
  parameter int unsigned HOLDOFF_US = 500
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             trig,
  input  logic [ON_US_W-1:0]               on_us,
  input  logic                             drv,
  input  logic                             ocd,
  output logic                             gate,
  output logic                             active,
  output logic                             fault,
  output logic [$clog2(MAX_CYCLES+1)-1:0]  cycles
);

  localparam int unsigned CYC_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned PRESC_W    = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int unsigned DRAIN_CLKS = DRAIN_US * CLK_MHZ;
  localparam int unsigned HOLD_CLKS  = HOLDOFF_US * CLK_MHZ;
  localparam int unsigned DRAIN_W    = $clog2(DRAIN_CLKS + 1);
  localparam int unsigned HOLD_W     = $clog2(HOLD_CLKS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_trig_d;
  logic               r_drv_d;
  logic [PRESC_W-1:0] r_presc;
  logic [ON_US_W-1:0] r_on_cnt;
  logic [CYC_W-1:0]   r_cycles;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_gate;
  logic               r_active;

  logic w_trig_rise;
  logic w_drv_fall;
  logic w_tick;
  logic w_start;
  logic w_on_done;
  logic w_cyc_done;
  logic w_ocd_hit;
  logic w_drain_done;
  logic w_hold_done;

  // Edge detects and terminal-count decodes
  assign w_trig_rise  = trig && !r_trig_d;
  assign w_drv_fall   = !drv && r_drv_d;
  assign w_tick       = (r_presc == PRESC_W'(CLK_MHZ - 1));
  assign w_start      = (r_state == S_IDLE) && w_trig_rise && (on_us != '0);
  assign w_on_done    = w_tick && (r_on_cnt == ON_US_W'(1));
  // The fall that brings the count to the limit ends the burst on that edge
  assign w_cyc_done   = w_drv_fall && (r_cycles == CYC_W'(MAX_CYCLES - 1));
  // Drain needs DRAIN_CLKS consecutive low samples; a high sample restarts it
  assign w_drain_done = !drv && (r_drain_cnt == DRAIN_W'(DRAIN_CLKS - 1));
  assign w_hold_done  = (r_hold_cnt == HOLD_W'(HOLD_CLKS - 1));

`ifdef BURST_SCHEDULER_OCD_EN
  logic r_fault;

  assign w_ocd_hit = (r_state == S_RUN) && ocd;

  // Sticky overcurrent flag, cleared only by an accepted trigger
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_start) begin
      r_fault <= 1'b0;
    end else if (w_ocd_hit) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  logic w_unused_ocd;

  assign w_unused_ocd = ocd;
  assign w_ocd_hit    = 1'b0;
  assign fault        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_on_done || w_cyc_done || w_ocd_hit) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_hold_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs registered from the next state so they track the state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gate   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_gate   <= (w_state_nxt == S_RUN);
      r_active <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    end
  end

  // Per-state counters; each counter is cleared in the state before it runs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trig_d    <= 1'b0;
      r_drv_d     <= 1'b0;
      r_presc     <= '0;
      r_on_cnt    <= '0;
      r_cycles    <= '0;
      r_drain_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_trig_d <= trig;
      r_drv_d  <= drv;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_on_cnt <= on_us;
            r_presc  <= '0;
            r_cycles <= '0;
          end
        end
        S_RUN: begin
          r_drain_cnt <= '0;
          r_presc     <= w_tick ? '0 : r_presc + PRESC_W'(1);
          if (w_tick && (r_on_cnt > ON_US_W'(1))) begin
            r_on_cnt <= r_on_cnt - ON_US_W'(1);
          end
          if (w_drv_fall && (r_cycles != CYC_W'(MAX_CYCLES))) begin
            r_cycles <= r_cycles + CYC_W'(1);
          end
        end
        S_DRAIN: begin
          r_hold_cnt <= '0;
          if (drv) begin
            r_drain_cnt <= '0;
          end else if (!w_drain_done) begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
          end
        end
        S_HOLD: begin
          if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          r_presc <= '0;
        end
      endcase
    end
  end

  assign gate   = r_gate;
  assign active = r_active;
  assign cycles = r_cycles;

endmodule

// File: tb/tb_burst_scheduler.sv
// Bench for burst_scheduler with CLK_MHZ=10, MAX_CYCLES=8, DRAIN_US=2,
// HOLDOFF_US=10. Inputs and samples happen on the falling clock edge.
module tb_burst_scheduler;

  localparam int unsigned CLK_MHZ    = 10;
  localparam int unsigned ON_US_W    = 10;
  localparam int unsigned MAX_CYCLES = 8;
  localparam int unsigned DRAIN_US   = 2;
  localparam int unsigned HOLDOFF_US = 10;
  localparam int DRAIN_CLKS = 20;
  localparam int HOLD_CLKS  = 100;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                trig;
  logic [ON_US_W-1:0]  on_us;
  logic                drv;
  logic                ocd;
  logic                gate;
  logic                active;
  logic                fault;
  logic [3:0]          cycles;

  int n_chk  = 0;
  int n_pass = 0;
  int drv_p  = 0;
  int drv_c  = 0;

  typedef struct {
    int on;
    int p;
    int exp_gate;
    int exp_cyc;
  } vec_t;

  vec_t vecs[7];

  burst_scheduler #(
    .CLK_MHZ   (CLK_MHZ),
    .ON_US_W   (ON_US_W),
    .MAX_CYCLES(MAX_CYCLES),
    .DRAIN_US  (DRAIN_US),
    .HOLDOFF_US(HOLDOFF_US)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (trig),
    .on_us (on_us),
    .drv   (drv),
    .ocd   (ocd),
    .gate  (gate),
    .active(active),
    .fault (fault),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  // Advance to the next falling edge; drv toggles every drv_p clocks while gate is high
  task automatic cyc();
    @(negedge clk);
    if (gate !== 1'b1 || drv_p == 0) begin
      drv   = 1'b0;
      drv_c = 0;
    end else begin
      drv_c++;
      if (drv_c == drv_p) begin
        drv   = ~drv;
        drv_c = 0;
      end
    end
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((gate || active) && b < 3000) begin
      b++;
      cyc();
    end
    chk("burst_end_timeout", int'(gate || active), 0);
    repeat (HOLD_CLKS) cyc();
  endtask

  task automatic run_burst(input int on, input int p, input int eg, input int ec,
                           input bit skip_hold);
    int g;
    int d;
    on_us = ON_US_W'(on);
    drv_p = p;
    trig  = 1'b1;
    cyc();
    chk("trig_to_gate", int'(gate), 1);
    trig = 1'b0;
    g = 0;
    while (gate && g < 2000) begin
      g++;
      cyc();
    end
    chk("gate_clks", g, eg);
    chk("cycles_at_end", int'(cycles), ec);
    chk("fault_after_trig", int'(fault), 0);
    chk("active_in_drain", int'(active), 1);
    d = 0;
    while (active && d < 2000) begin
      d++;
      cyc();
    end
    chk("drain_clks", d, DRAIN_CLKS);
    chk("cycles_frozen", int'(cycles), ec);
    if (!skip_hold) repeat (HOLD_CLKS) cyc();
  endtask

  initial begin
    int d;
    int g;
    int bad;

    vecs[0] = '{on: 3,    p: 5,   exp_gate: 30, exp_cyc: 3};
    vecs[1] = '{on: 100,  p: 2,   exp_gate: 32, exp_cyc: 8};
    vecs[2] = '{on: 1,    p: 3,   exp_gate: 10, exp_cyc: 1};
    vecs[3] = '{on: 2,    p: 200, exp_gate: 20, exp_cyc: 0};
    vecs[4] = '{on: 5,    p: 3,   exp_gate: 48, exp_cyc: 8};
    vecs[5] = '{on: 4,    p: 5,   exp_gate: 40, exp_cyc: 4};
    vecs[6] = '{on: 1023, p: 1,   exp_gate: 16, exp_cyc: 8};

    rst_n = 1'b0;
    trig  = 1'b0;
    on_us = '0;
    drv   = 1'b0;
    ocd   = 1'b0;
    repeat (3) cyc();
    chk("rst_gate", int'(gate), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_cycles", int'(cycles), 0);
    rst_n = 1'b1;
    cyc();

    // Zero on-time request is ignored
    on_us = '0;
    trig  = 1'b1;
    cyc();
    chk("zero_on_gate", int'(gate), 0);
    cyc();
    chk("zero_on_active", int'(active), 0);
    trig = 1'b0;
    cyc();

    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i].on, vecs[i].p, vecs[i].exp_gate, vecs[i].exp_cyc, 1'b0);
    end

    // Drain restarts when drv goes high 15 clocks into DRAIN
    on_us = ON_US_W'(1);
    drv_p = 0;
    trig  = 1'b1;
    cyc();
    trig = 1'b0;
    g = 0;
    while (gate && g < 2000) begin
      g++;
      cyc();
    end
    chk("ext_gate_clks", g, 10);
    d = 0;
    while (active && d < 2000) begin
      if (d >= 15 && d <= 17) drv = 1'b1;
      d++;
      cyc();
    end
    chk("ext_drain_clks", d, 38);
    repeat (HOLD_CLKS) cyc();

    // Holdoff lockout: mid-holdoff edge dropped, edge on last holdoff clock dropped
    run_burst(1, 0, 10, 0, 1'b1);
    repeat (50) cyc();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    chk("lock_mid_gate", int'(gate), 0);
    chk("lock_mid_active", int'(active), 0);
    repeat (48) cyc();
    trig = 1'b1;
    bad = 0;
    repeat (6) begin
      cyc();
      if (gate || active) bad = 1;
    end
    chk("lock_held_high", bad, 0);
    trig = 1'b0;
    cyc();
    trig = 1'b1;
    cyc();
    chk("rearm_gate", int'(gate), 1);
    trig = 1'b0;
    wait_done();

`ifdef BURST_SCHEDULER_OCD_EN
    on_us = ON_US_W'(10);
    drv_p = 5;
    trig  = 1'b1;
    cyc();
    trig = 1'b0;
    repeat (24) cyc();
    ocd = 1'b1;
    cyc();
    ocd = 1'b0;
    chk("ocd_gate", int'(gate), 0);
    chk("ocd_fault", int'(fault), 1);
    chk("ocd_active", int'(active), 1);
    chk("ocd_cycles", int'(cycles), 2);
    wait_done();
    ocd = 1'b1;
    cyc();
    ocd = 1'b0;
    cyc();
    chk("ocd_idle_sticky", int'(fault), 1);
    chk("ocd_idle_active", int'(active), 0);
    run_burst(3, 5, 30, 3, 1'b0);
`else
    on_us = ON_US_W'(10);
    drv_p = 5;
    trig  = 1'b1;
    cyc();
    trig = 1'b0;
    repeat (24) cyc();
    ocd = 1'b1;
    cyc();
    ocd = 1'b0;
    chk("ocd_off_gate", int'(gate), 1);
    chk("ocd_off_fault", int'(fault), 0);
    g = 25;
    while (gate && g < 2000) begin
      g++;
      cyc();
    end
    chk("ocd_off_gate_clks", g, 80);
    chk("ocd_off_cycles", int'(cycles), 8);
    wait_done();
`endif

    // Reset at RUN clock 12
    on_us = ON_US_W'(3);
    drv_p = 5;
    trig  = 1'b1;
    cyc();
    trig = 1'b0;
    repeat (11) cyc();
    chk("pre_rst_cycles", int'(cycles), 1);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_gate", int'(gate), 0);
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_cycles", int'(cycles), 0);
    chk("mid_rst_fault", int'(fault), 0);
    rst_n = 1'b1;
    cyc();
    run_burst(2, 200, 20, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
